// File: rtl/sisc_ifetch.sv
// sisc_ifetch -- SISC instruction fetch stage.
//
// Owns the program counter, addresses instruction memory with it, and captures
// the combinationally returned instruction word into a 2-entry prefetch buffer
// that feeds decode over a valid/ready handshake. A branch redirect flushes the
// buffer and reloads the PC, taking priority over everything except reset.
//
// Optional feature: define SISC_IFETCH_HALT_EN to stop fetching after a word
// with opcode 4'hF (HALT) has been buffered; without it, halted is tied 0.
//
// Ports:
//   clk            system clock, rising edge
//   rst_f          asynchronous active-low reset
//   im_addr        word address to instruction memory (the PC register)
//   im_data        instruction word for im_addr, same cycle
//   ir / ir_pc     instruction and address at the buffer head
//   ir_valid       buffer head holds a valid instruction
//   ir_ready       decode accepts the head this cycle
//   redirect       branch taken: flush and load a new PC
//   redirect_rel   1: target = redirect_base + 1 + redirect_imm; 0: redirect_imm
//   redirect_base  PC of the branching instruction
//   redirect_imm   branch immediate or absolute target
//   buf_count      buffer occupancy, 0..2
//   halted         fetch stopped on HALT
module sisc_ifetch #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic              redirect_rel,
  input  logic [ADDR_W-1:0] redirect_base,
  input  logic [ADDR_W-1:0] redirect_imm,
  output logic [1:0]        buf_count,
  output logic              halted
);

`ifdef SISC_IFETCH_HALT_EN
  typedef enum logic [1:0] {S_RUN, S_HOLD, S_HALTED} state_t;
`else
  typedef enum logic [1:0] {S_RUN, S_HOLD} state_t;
`endif

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   head_data, tail_data;
  logic [ADDR_W-1:0]   head_pc, tail_pc;
  logic [1:0]          count, count_nxt, count_after_pop;
  logic                pop, push, fetch_ok, is_halt;

  // Target arithmetic wraps at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] redirect_target(
    input logic              rel,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] imm
  );
    if (rel) return base + ADDR_W'(1) + imm;
    else     return imm;
  endfunction

  // RUN implies room in the buffer; HOLD means full, so only a pop frees a slot.
  assign pop = (count != 2'd0) & ir_ready;
`ifdef SISC_IFETCH_HALT_EN
  assign fetch_ok = (state == S_RUN) | ((state == S_HOLD) & pop);
  assign is_halt  = (im_data[DATA_W-1 -: 4] == 4'hF);
`else
  assign fetch_ok = (state == S_RUN) | pop;
  assign is_halt  = 1'b0;
`endif
  assign push = fetch_ok & ~redirect;

  always_comb begin
    count_nxt = count;
    if (push & ~pop)      count_nxt = count + 2'd1;
    else if (pop & ~push) count_nxt = count - 2'd1;
  end

  // Slot the incoming word lands in, once the head has been popped.
  assign count_after_pop = count - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= S_RUN;
      pc        <= RESET_PC;
      count     <= 2'd0;
      head_data <= '0;
      head_pc   <= '0;
      tail_data <= '0;
      tail_pc   <= '0;
    end else if (redirect) begin
      // Head is discarded, so a concurrent pop has no effect.
      state <= S_RUN;
      pc    <= redirect_target(redirect_rel, redirect_base, redirect_imm);
      count <= 2'd0;
    end else begin
      count <= count_nxt;
      if (pop && count == 2'd2) begin
        head_data <= tail_data;
        head_pc   <= tail_pc;
      end
      if (push) begin
        pc <= pc + ADDR_W'(1);
        if (count_after_pop == 2'd0) begin
          head_data <= im_data;
          head_pc   <= pc;
        end else begin
          tail_data <= im_data;
          tail_pc   <= pc;
        end
      end
`ifdef SISC_IFETCH_HALT_EN
      if (state == S_HALTED)     state <= S_HALTED;
      else if (push && is_halt)  state <= S_HALTED;
      else                       state <= (count_nxt == 2'd2) ? S_HOLD : S_RUN;
`else
      state <= (count_nxt == 2'd2) ? S_HOLD : S_RUN;
`endif
    end
  end

  assign im_addr   = pc;
  assign ir        = head_data;
  assign ir_pc     = head_pc;
  assign ir_valid  = (count != 2'd0);
  assign buf_count = count;
`ifdef SISC_IFETCH_HALT_EN
  assign halted    = (state == S_HALTED);
`else
  assign halted    = 1'b0;
`endif

endmodule
